// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the LED PWM fade sequencer.
package pwm_pkg;

  localparam int unsigned      PWM_W   = 8;
  localparam logic [PWM_W-1:0] PWM_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Counts PWM period events and flags the event on which the count reaches a runtime limit.
// The counter clears itself on that terminal event so the next phase starts from zero.
module pwm_period_timer
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             clr,
  input  logic [PWM_W-1:0] limit,
  output logic             tc
);

  logic [PWM_W-1:0] pcnt;

  assign tc = evt && !clr && (pcnt == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (evt) begin
      pcnt <= tc ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_fade_controller.sv
// Breathing-pattern sequencer for the LED PWM Duty input; Duty moves only at PWM period boundaries.
// Build option PWM_FADE_LOOP_EN: repeat the pattern until Stop/Reset instead of running once.
module pwm_fade_controller
  import pwm_pkg::*;
#(
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned HOLD_PERIODS = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic [PWM_W-1:0] Target,
  input  logic [PWM_W-1:0] Step,
  input  logic [PWM_W-1:0] PwmQ,
  output logic [PWM_W-1:0] Duty,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       State
);

  localparam logic [PWM_W-1:0] STEP_LIM = PWM_W'(STEP_PERIODS - 1);
  localparam logic [PWM_W-1:0] HOLD_LIM = PWM_W'(HOLD_PERIODS - 1);

  state_t           state;
  logic [PWM_W-1:0] tgt;
  logic [PWM_W-1:0] stp;
  logic [PWM_W-1:0] limit;
  logic [PWM_W-1:0] up_duty;
  logic [PWM_W-1:0] dn_duty;
  logic [PWM_W:0]   sum;
  logic             evt;
  logic             clr;
  logic             tc;

  assign evt   = (PwmQ == PWM_MAX);
  assign clr   = Stop || (state == ST_IDLE);
  assign State = state;
  assign Busy  = (state != ST_IDLE);

  // Up-step is summed one bit wider so the clamp to tgt cannot be fooled by wrap.
  always_comb begin
    limit   = (state == ST_UP || state == ST_DOWN) ? STEP_LIM : HOLD_LIM;
    sum     = {1'b0, Duty} + {1'b0, stp};
    up_duty = (sum > {1'b0, tgt}) ? tgt : sum[PWM_W-1:0];
    dn_duty = (Duty > stp) ? Duty - stp : '0;
  end

  pwm_period_timer u_timer (
    .clk  (Clock),
    .rst  (Reset),
    .evt  (evt),
    .clr  (clr),
    .limit(limit),
    .tc   (tc)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      Duty  <= '0;
      Done  <= 1'b0;
      tgt   <= '0;
      stp   <= '0;
    end else begin
      Done <= 1'b0;
      if (Stop) begin
        state <= ST_IDLE;
        Duty  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            Duty <= '0;
            if (Start) begin
              tgt   <= Target;
              stp   <= (Step == '0) ? PWM_W'(1) : Step;
              state <= ST_UP;
            end
          end
          ST_UP: begin
            if (tc) begin
              Duty <= up_duty;
              if (up_duty == tgt) state <= ST_HOLD_HI;
            end
          end
          ST_HOLD_HI: begin
            if (tc) state <= ST_DOWN;
          end
          ST_DOWN: begin
            if (tc) begin
              Duty <= dn_duty;
              if (dn_duty == '0) state <= ST_HOLD_LO;
            end
          end
          ST_HOLD_LO: begin
            if (tc) begin
              Done <= 1'b1;
`ifdef PWM_FADE_LOOP_EN
              state <= ST_UP;
`else
              state <= ST_IDLE;
`endif
            end
          end
          default: begin
            state <= ST_IDLE;
            Duty  <= '0;
          end
        endcase
      end
    end
  end

endmodule
